// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester memory port arbiter.
// Holds the FSM encoding, the data width and the default access latency.
package mem_port_arbiter_pkg;

  localparam int DATA_W      = 16;
  localparam int MEM_LAT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mux16b2.sv
// 16-bit two-input multiplexer: y follows a when set is low, b when set is high.
module mux16b2 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        set,
  output logic [15:0] y
);

  assign y = set ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single memory port shared by fetch (0) and LSU (1).
// Grants one fixed-latency access at a time and returns read data with a done pulse.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              sel
);

  state_t           state, state_n;
  logic             last;
  logic [CNT_W-1:0] cnt;
  logic             any_req;
  logic             winner;
  logic             we_sel;

  // On a tie the requester that did not win last time goes next.
  assign any_req = req0 | req1;
  assign winner  = (req0 & req1) ? ~last : req1;
  assign we_sel  = sel ? we1 : we0;

  // NOTE: every output of a combinational block gets a default before the case so no latch is inferred.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = ACCESS;
      ACCESS:  if (cnt == '0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel   <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      rdata <= '0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            sel  <= winner;
            last <= winner;
            gnt0 <= ~winner;
            gnt1 <= winner;
            cnt  <= CNT_W'(MEM_LAT - 1);
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            // A write completes without disturbing the last read result.
            if (!we_sel) rdata <= mem_rdata;
            done0 <= ~sel;
            done1 <= sel;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_en = (state == ACCESS);
  assign mem_we = mem_en & we_sel;

  mux16b2 u_addr_mux (
    .a   (addr0),
    .b   (addr1),
    .set (sel),
    .y   (mem_addr)
  );

  mux16b2 u_wdata_mux (
    .a   (wdata0),
    .b   (wdata1),
    .set (sel),
    .y   (mem_wdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MEM_LAT=2 main instance,
// plus a MEM_LAT=1 instance sharing the same stimulus).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, wdata0, addr1, wdata1, mem_rdata;

  logic        gnt0, gnt1, done0, done1, mem_en, mem_we, sel;
  logic [15:0] rdata, mem_addr, mem_wdata;

  logic        l1_gnt0, l1_gnt1, l1_done0, l1_done1, l1_mem_en, l1_mem_we, l1_sel;
  logic [15:0] l1_rdata, l1_mem_addr, l1_mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(2), .CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .sel(sel)
  );

  mem_port_arbiter #(.MEM_LAT(1), .CNT_W(4)) u_dut_lat1 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(l1_gnt0), .gnt1(l1_gnt1), .done0(l1_done0), .done1(l1_done1),
    .rdata(l1_rdata), .mem_en(l1_mem_en), .mem_we(l1_mem_we),
    .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata), .mem_rdata(mem_rdata),
    .sel(l1_sel)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle 2 time units past it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    mem_rdata = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int gnt_who [4];
    int gnt_cyc [4];
    int n_gnt;
    int overlap;
    int extra;

    // ---- reset state ----
    do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_sel",    sel,    1'b0);
    check("rst_gnt",    {gnt0, gnt1},   2'b00);
    check("rst_done",   {done0, done1}, 2'b00);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_rdata",  rdata,  16'h0000);
    rst_n = 1'b1;

    // ---- single read by requester 0 ----
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h000F; mem_rdata = 16'hBEEF;
    step();
    check("rd_gnt0",     gnt0,     1'b1);
    check("rd_sel",      sel,      1'b0);
    check("rd_en_c1",    mem_en,   1'b1);
    check("rd_we_c1",    mem_we,   1'b0);
    check("rd_addr_c1",  mem_addr, 16'h000F);
    req0 = 1'b0;
    step();
    check("rd_gnt0_clr", gnt0,     1'b0);
    check("rd_en_c2",    mem_en,   1'b1);
    check("rd_addr_c2",  mem_addr, 16'h000F);
    step();
    check("rd_done0",    done0,    1'b1);
    check("rd_done1",    done1,    1'b0);
    check("rd_rdata",    rdata,    16'hBEEF);
    check("rd_en_done",  mem_en,   1'b0);
    step();
    check("rd_done_clr", done0,    1'b0);
    check("rd_rdata_hold", rdata,  16'hBEEF);

    // ---- single write by requester 1 ----
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h003F; wdata1 = 16'h1234; mem_rdata = 16'h5555;
    step();
    check("wr_gnt1",    gnt1,      1'b1);
    check("wr_sel",     sel,       1'b1);
    check("wr_we_c1",   mem_we,    1'b1);
    check("wr_addr",    mem_addr,  16'h003F);
    check("wr_wdata",   mem_wdata, 16'h1234);
    req1 = 1'b0;
    step();
    check("wr_we_c2",   mem_we,    1'b1);
    check("wr_en_c2",   mem_en,    1'b1);
    step();
    check("wr_done1",   done1,     1'b1);
    check("wr_we_done", mem_we,    1'b0);
    check("wr_rdata",   rdata,     16'hBEEF);
    step();
    check("wr_done_clr", done1,    1'b0);
    we1 = 1'b0;

    // ---- tie after reset: strict alternation, spacing MEM_LAT+2 ----
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    n_gnt = 0; overlap = 0;
    for (int c = 1; c <= 16; c++) begin
      step();
      if ((gnt0 & gnt1) || (done0 & done1) || ((gnt0 | gnt1) && (done0 | done1)))
        overlap++;
      if ((gnt0 | gnt1) && n_gnt < 4) begin
        gnt_who[n_gnt] = gnt1 ? 1 : 0;
        gnt_cyc[n_gnt] = c;
        n_gnt++;
      end
    end
    check("tie_n_gnt", n_gnt, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tie_who%0d", i), gnt_who[i], i % 2);
      check($sformatf("tie_cyc%0d", i), gnt_cyc[i], 1 + 4 * i);
    end
    check("tie_overlap", overlap, 0);

    // ---- request dropped in first ACCESS cycle ----
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010; mem_rdata = 16'hA5A5;
    step();
    check("drop_gnt0", gnt0, 1'b1);
    req0 = 1'b0;
    step();
    check("drop_en", mem_en, 1'b1);
    step();
    check("drop_done0", done0, 1'b1);
    check("drop_rdata", rdata, 16'hA5A5);
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (gnt0 | gnt1 | done0 | done1 | mem_en) extra++;
    end
    check("drop_no_regrant", extra, 0);

    // ---- async reset in mid-ACCESS ----
    do_reset();
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0042;
    step();
    check("ar_gnt1", gnt1, 1'b1);
    check("ar_sel1", sel,  1'b1);
    step();
    check("ar_en_pre", mem_en, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_en",    mem_en, 1'b0);
    check("ar_sel",   sel,    1'b0);
    check("ar_pulse", {gnt0, gnt1, done0, done1}, 4'b0000);
    extra = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (done0 | done1 | gnt0 | gnt1 | mem_en) extra++;
    end
    check("ar_no_done", extra, 0);
    rst_n = 1'b1;
    step();
    check("ar_regnt1", gnt1, 1'b1);
    check("ar_regnt0", gnt0, 1'b0);
    req1 = 1'b0;

    // ---- MEM_LAT=1 build ----
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0007; mem_rdata = 16'h1357;
    step();
    check("l1_gnt0",  l1_gnt0,     1'b1);
    check("l1_en_c1", l1_mem_en,   1'b1);
    check("l1_addr",  l1_mem_addr, 16'h0007);
    req0 = 1'b0;
    step();
    check("l1_en_c2", l1_mem_en,   1'b0);
    check("l1_done0", l1_done0,    1'b1);
    check("l1_rdata", l1_rdata,    16'h1357);
    step();
    check("l1_done_clr", l1_done0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
